debug_host: RTL and testbench

- Host-side master for the CPU wrapper's debug port. It drives debug_en, debug_step and debug_addr, and reads debug_data.
- Issues single-step pulses to the core. After each step (or on demand) it scans debug addresses 0..NUM_ADDR-1 and streams each captured word out on a valid/ready interface, for display or UART logic.
- Sits between board-level controls and the CPU wrapper in the top level.

---
 rtl/debug_host.sv | 142 ++++++++++++++
 tb/tb_debug_host.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host.sv
// Host-side master for the CPU wrapper's debug port.
// Issues single-step pulses to the core and scans debug addresses 0..NUM_ADDR-1.
// Each captured word is streamed out on a valid/ready interface.
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   mode_debug               hold core in debug mode (registered onto debug_en)
//   step_req, scan_req       one-cycle requests, honoured only while idle
//   debug_en/step/addr       drive the wrapper debug port
//   debug_data               word read back from the wrapper
//   out_valid/ready/addr/data  captured-word stream
//   busy                     high whenever the FSM is not idle
//   scan_done                one-cycle pulse after the last word is accepted
//   step_count               number of step pulses issued (wraps)
module debug_host #(
  parameter int unsigned NUM_ADDR   = 128,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_debug,
  input  logic        step_req,
  input  logic        scan_req,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        scan_done,
  output logic [31:0] step_count
);

  typedef enum logic [2:0] {
    StIdle, StStep, StSettle, StAddr, StWait, StPush, StDone
  } state_e;

  localparam logic [6:0]  LastIdx   = 7'(NUM_ADDR - 1);
  localparam logic [15:0] SettleEnd = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] WaitEnd   = 16'(READ_LAT - 1);

  state_e      state_q;
  logic [6:0]  idx_q;
  logic [15:0] cnt_q;

  // All outputs are registered: each is loaded on the edge that enters the
  // state in which it must be visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      cnt_q      <= '0;
      debug_en   <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      scan_done  <= 1'b0;
      step_count <= '0;
    end else begin
      debug_en   <= mode_debug;
      debug_step <= 1'b0;
      scan_done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A step also covers a simultaneous scan request.
          if (step_req && mode_debug) begin
            state_q    <= StStep;
            debug_step <= 1'b1;
            step_count <= step_count + 32'd1;
            busy       <= 1'b1;
          end else if (scan_req) begin
            state_q    <= StAddr;
            idx_q      <= '0;
            debug_addr <= '0;
            busy       <= 1'b1;
          end
        end
        StStep: begin
          if (SETTLE_CYC == 0) begin
            state_q    <= StAddr;
            idx_q      <= '0;
            debug_addr <= '0;
          end else begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
        end
        StSettle: begin
          if (cnt_q == SettleEnd) begin
            state_q    <= StAddr;
            idx_q      <= '0;
            debug_addr <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StAddr: begin
          state_q <= StWait;
          cnt_q   <= '0;
        end
        StWait: begin
          if (cnt_q == WaitEnd) begin
            out_data  <= debug_data;
            out_addr  <= idx_q;
            out_valid <= 1'b1;
            state_q   <= StPush;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StPush: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_q == LastIdx) begin
              state_q   <= StDone;
              scan_done <= 1'b1;
            end else begin
              idx_q      <= idx_q + 7'd1;
              debug_addr <= idx_q + 7'd1;
              state_q    <= StAddr;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host.sv
// Bench for debug_host: a default instance (dut0) and a NUM_ADDR=4, READ_LAT=3,
// SETTLE_CYC=0 instance (dut1). Each wrapper model only returns valid data once
// the address has been held long enough, so an early sample shows up as 0xDEADBEEF.
module tb_debug_host;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        mode_debug0 = 0, step_req0 = 0, scan_req0 = 0, out_ready0 = 0;
  logic        debug_en0, debug_step0, out_valid0, busy0, scan_done0;
  logic [6:0]  debug_addr0, out_addr0;
  logic [31:0] debug_data0, out_data0, step_count0;

  logic        mode_debug1 = 0, step_req1 = 0, scan_req1 = 0, out_ready1 = 0;
  logic        debug_en1, debug_step1, out_valid1, busy1, scan_done1;
  logic [6:0]  debug_addr1, out_addr1;
  logic [31:0] debug_data1, out_data1, step_count1;

  debug_host dut0 (
    .clk(clk), .rst(rst), .mode_debug(mode_debug0), .step_req(step_req0),
    .scan_req(scan_req0), .debug_en(debug_en0), .debug_step(debug_step0),
    .debug_addr(debug_addr0), .debug_data(debug_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_addr(out_addr0), .out_data(out_data0), .busy(busy0),
    .scan_done(scan_done0), .step_count(step_count0)
  );

  debug_host #(.NUM_ADDR(4), .READ_LAT(3), .SETTLE_CYC(0)) dut1 (
    .clk(clk), .rst(rst), .mode_debug(mode_debug1), .step_req(step_req1),
    .scan_req(scan_req1), .debug_en(debug_en1), .debug_step(debug_step1),
    .debug_addr(debug_addr1), .debug_data(debug_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_addr(out_addr1), .out_data(out_data1), .busy(busy1),
    .scan_done(scan_done1), .step_count(step_count1)
  );

  function automatic logic [31:0] model_data(input logic [6:0] a);
    return {~a, 1'b0, a, 8'h5A, a, 2'b11};
  endfunction

  // Wrapper models: data is valid once the address has been stable for the
  // read latency (age counts edges since the address last changed).
  logic [6:0] prev0 = '0, prev1 = '0;
  logic [7:0] age0 = '0, age1 = '0;
  always @(posedge clk) begin
    prev0 <= debug_addr0;
    prev1 <= debug_addr1;
    age0  <= (debug_addr0 != prev0) ? 8'd0 : ((age0 == 8'hFF) ? age0 : age0 + 8'd1);
    age1  <= (debug_addr1 != prev1) ? 8'd0 : ((age1 == 8'hFF) ? age1 : age1 + 8'd1);
  end
  assign debug_data0 = (debug_addr0 == prev0 && age0 >= 8'd0) ? model_data(debug_addr0)
                                                               : 32'hDEAD_BEEF;
  assign debug_data1 = (debug_addr1 == prev1 && age1 >= 8'd2) ? model_data(debug_addr1)
                                                               : 32'hDEAD_BEEF;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expected {addr, data} pushed when a scan is launched.
  logic [38:0] q0[$];
  logic [38:0] q1[$];
  int hs0 = 0, hs1 = 0, steps0 = 0;

  task automatic push_scan0();
    for (int i = 0; i < 128; i++) q0.push_back({7'(i), model_data(7'(i))});
  endtask

  task automatic push_scan1();
    for (int i = 0; i < 4; i++) q1.push_back({7'(i), model_data(7'(i))});
  endtask

  always @(negedge clk) begin
    logic [38:0] e;
    if (rst && debug_step0) steps0++;
    if (rst && out_valid0 && out_ready0) begin
      hs0++;
      if (q0.size() == 0) begin
        check("dut0_unexpected_word", 32'(out_addr0), 32'h7F);
      end else begin
        e = q0.pop_front();
        check("dut0_out_addr", 32'(out_addr0), 32'(e[38:32]));
        check("dut0_out_data", out_data0, e[31:0]);
      end
    end
    if (rst && out_valid1 && out_ready1) begin
      hs1++;
      if (q1.size() == 0) begin
        check("dut1_unexpected_word", 32'(out_addr1), 32'h7F);
      end else begin
        e = q1.pop_front();
        check("dut1_out_addr", 32'(out_addr1), 32'(e[38:32]));
        check("dut1_out_data", out_data1, e[31:0]);
      end
    end
  end

  task automatic wait_done0(input int bound, output int n);
    n = 0;
    while (!scan_done0 && n < bound) begin
      tick();
      n++;
    end
    check("dut0_scan_done_reached", 32'(scan_done0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_debug_en0"}, 32'(debug_en0), 0);
    check({tag, "_debug_step0"}, 32'(debug_step0), 0);
    check({tag, "_debug_addr0"}, 32'(debug_addr0), 0);
    check({tag, "_out_valid0"}, 32'(out_valid0), 0);
    check({tag, "_out_addr0"}, 32'(out_addr0), 0);
    check({tag, "_out_data0"}, out_data0, 0);
    check({tag, "_busy0"}, 32'(busy0), 0);
    check({tag, "_scan_done0"}, 32'(scan_done0), 0);
    check({tag, "_step_count0"}, step_count0, 0);
    check({tag, "_busy1"}, 32'(busy1), 0);
    check({tag, "_out_valid1"}, 32'(out_valid1), 0);
    check({tag, "_step_count1"}, step_count1, 0);
    check({tag, "_debug_en1"}, 32'(debug_en1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, s;
    // 1. Reset with random inputs.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mode_debug0 = 1'($urandom); step_req0 = 1'($urandom);
      scan_req0 = 1'($urandom); out_ready0 = 1'($urandom);
      mode_debug1 = 1'($urandom); step_req1 = 1'($urandom);
      scan_req1 = 1'($urandom); out_ready1 = 1'($urandom);
      tick();
    end
    check_all_zero("reset");
    mode_debug0 = 0; step_req0 = 0; scan_req0 = 0; out_ready0 = 1;
    mode_debug1 = 0; step_req1 = 0; scan_req1 = 0; out_ready1 = 1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_all_zero("post_reset");

    // 2. Step with defaults, exact timing.
    mode_debug0 = 1;
    tick();
    check("debug_en_follows", 32'(debug_en0), 1);
    push_scan0();
    h = hs0;
    step_req0 = 1;
    tick();  // cycle k+1
    step_req0 = 0;
    check("step_pulse", 32'(debug_step0), 1);
    check("step_count_1", step_count0, 1);
    check("busy_in_step", 32'(busy0), 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      check("no_valid_before_k6", 32'(out_valid0), 0);
      check("step_pulse_single", 32'(debug_step0), 0);
    end
    tick();  // cycle k+6
    check("first_valid_k6", 32'(out_valid0), 1);
    check("first_addr_0", 32'(out_addr0), 0);
    wait_done0(600, n);
    check("scan_done_cycle", 32'(n), 32'd382);
    tick();
    check("scan_done_single", 32'(scan_done0), 0);
    check("busy_falls", 32'(busy0), 0);
    check("step_scan_words", 32'(hs0 - h), 128);
    check("step_scan_queue_empty", 32'(q0.size()), 0);

    // 3. Backpressure at address 5.
    push_scan0();
    h = hs0;
    scan_req0 = 1;
    tick();
    scan_req0 = 0;
    n = 0;
    while (!(out_valid0 && out_addr0 == 7'd5) && n < 100) begin
      tick();
      n++;
    end
    out_ready0 = 0;
    check("bp_reached_addr5", 32'(out_addr0), 5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid_held", 32'(out_valid0), 1);
      check("bp_addr_held", 32'(out_addr0), 5);
      check("bp_data_held", out_data0, model_data(7'd5));
    end
    out_ready0 = 1;
    wait_done0(600, n);
    tick();
    check("bp_words", 32'(hs0 - h), 128);
    check("bp_queue_empty", 32'(q0.size()), 0);

    // 4a. Step while not in debug mode is ignored.
    mode_debug0 = 0;
    tick();
    tick();
    s = steps0;
    step_req0 = 1;
    tick();
    step_req0 = 0;
    check("gated_no_step", 32'(debug_step0), 0);
    check("gated_idle", 32'(busy0), 0);
    tick();
    check("gated_still_idle", 32'(busy0), 0);
    check("gated_count", step_count0, 1);

    // 4b. Step and scan together: one step, one scan.
    mode_debug0 = 1;
    tick();
    push_scan0();
    h = hs0;
    step_req0 = 1;
    scan_req0 = 1;
    tick();
    step_req0 = 0;
    scan_req0 = 0;
    check("prio_step_pulse", 32'(debug_step0), 1);
    check("prio_step_count", step_count0, 2);
    wait_done0(600, n);
    for (int i = 0; i < 4; i++) tick();
    check("prio_no_second_scan", 32'(busy0), 0);
    check("prio_words", 32'(hs0 - h), 128);
    check("prio_step_pulses", 32'(steps0 - s), 1);

    // 4c. Step request while busy is dropped.
    push_scan0();
    h = hs0;
    s = steps0;
    scan_req0 = 1;
    tick();
    scan_req0 = 0;
    for (int i = 0; i < 20; i++) tick();
    step_req0 = 1;
    tick();
    step_req0 = 0;
    wait_done0(600, n);
    for (int i = 0; i < 4; i++) tick();
    check("busy_step_count", step_count0, 2);
    check("busy_step_pulses", 32'(steps0 - s), 0);
    check("busy_step_idle_after", 32'(busy0), 0);
    check("busy_step_words", 32'(hs0 - h), 128);

    // 5. Reset mid-scan at address 40.
    push_scan0();
    scan_req0 = 1;
    tick();
    scan_req0 = 0;
    n = 0;
    while (!(out_valid0 && out_addr0 == 7'd40) && n < 300) begin
      tick();
      n++;
    end
    check("abort_reached_addr40", 32'(out_addr0), 40);
    rst = 1'b0;
    tick();
    check("abort_valid_low", 32'(out_valid0), 0);
    check("abort_busy_low", 32'(busy0), 0);
    rst = 1'b1;
    q0.delete();
    push_scan0();
    h = hs0;
    scan_req0 = 1;
    tick();
    scan_req0 = 0;
    n = 0;
    while (!out_valid0 && n < 20) begin
      tick();
      n++;
    end
    check("restart_addr0", 32'(out_addr0), 0);
    wait_done0(600, n);
    tick();
    check("restart_words", 32'(hs0 - h), 128);

    // 6. Variant instance: STEP -> ADDR directly, 5 cycles per word.
    mode_debug1 = 1;
    tick();
    push_scan1();
    step_req1 = 1;
    tick();  // cycle k+1
    step_req1 = 0;
    check("v_step_pulse", 32'(debug_step1), 1);
    check("v_step_count", step_count1, 1);
    for (int c = 2; c <= 23; c++) begin
      tick();
      check("v_valid", 32'(out_valid1), 32'((c >= 6 && c <= 21 && (c - 6) % 5 == 0) ? 1 : 0));
      check("v_scan_done", 32'(scan_done1), 32'((c == 22) ? 1 : 0));
      check("v_busy", 32'(busy1), 32'((c <= 22) ? 1 : 0));
      if (c >= 6 && c <= 21 && (c - 6) % 5 == 0)
        check("v_addr", 32'(out_addr1), 32'((c - 6) / 5));
    end
    check("v_words", 32'(hs1), 4);
    check("v_queue_empty", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
